// File: rtl/sdram_port_arbiter.sv
// Purpose: two-master round-robin arbiter in front of the single sys_sdram valid/ready port.
// Latency: request sampled in IDLE -> m_valid next cycle; m_ready at K -> pX_ready/pX_rdata at K+1; 3 cycles minimum per transaction.
// Backpressure: a master waits (valid held) until its one-cycle ready pulse; m_valid and m_* are held until m_ready.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   pN_valid/addr/wdata/wstrb        master N request (wstrb all-zero = read)
//   pN_ready/rdata                   master N completion pulse and read data
//   m_valid/addr/wdata/wstrb         registered request toward the controller
//   m_ready/rdata                    controller completion and read data
//   grant, busy                      current owner, FSM not idle
module sdram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                p0_valid,
  output logic                p0_ready,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_wstrb,
  output logic [DATA_W-1:0]   p0_rdata,

  input  logic                p1_valid,
  output logic                p1_ready,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_wstrb,
  output logic [DATA_W-1:0]   p1_rdata,

  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,

  output logic                grant,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   pick;

  // With both requesting, the port that did not win last time goes next;
  // with only one requesting, that one wins.
  always_comb begin
    pick = 1'b0;
    if (p0_valid && p1_valid) begin
      pick = ~last_grant;
    end else begin
      pick = p1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      busy       <= 1'b0;
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      p0_ready   <= 1'b0;
      p1_ready   <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      // Ready is a single-cycle pulse; only the REQ->RESP transition raises it.
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      case (state)
        IDLE: begin
          // Requester fields are sampled only here, so a master updating its
          // fields on its ready edge can never cause a stale re-issue.
          if (p0_valid || p1_valid) begin
            grant      <= pick;
            last_grant <= pick;
            m_addr     <= pick ? p1_addr  : p0_addr;
            m_wdata    <= pick ? p1_wdata : p0_wdata;
            m_wstrb    <= pick ? p1_wstrb : p0_wstrb;
            m_valid    <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // Dropping pX_valid here does not abort; the transaction completes.
          if (m_ready) begin
            m_valid <= 1'b0;
            if (grant) begin
              p1_rdata <= m_rdata;
              p1_ready <= 1'b1;
            end else begin
              p0_rdata <= m_rdata;
              p0_ready <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          m_valid <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_valid = 1'b0, p1_valid = 1'b0;
  logic        p0_ready, p1_ready;
  logic [31:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_wdata = '0, p1_wdata = '0;
  logic [3:0]  p0_wstrb = '0, p1_wstrb = '0;
  logic [31:0] p0_rdata, p1_rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;
  logic        grant, busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_rdata(p1_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .grant(grant), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one transaction for the given port. Starts just after the caller has
  // set up requester inputs; returns at the negedge of the IDLE cycle after RESP.
  task automatic run_txn(input int port, input int delay, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_wstrb, input bit drop, input bit scramble,
                         input bit stray);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    if (!seen) begin
      check("m_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("req_addr", m_addr, e_addr);
    check("req_wdata", m_wdata, e_wdata);
    check("req_wstrb", {28'd0, m_wstrb}, {28'd0, e_wstrb});
    check("req_grant", {31'd0, grant}, port);
    check("req_busy", {31'd0, busy}, 32'd1);
    if (scramble) begin
      if (port == 1) begin
        p1_addr = 32'hBAD0_0000; p1_wdata = 32'hFFFF_0000; p1_wstrb = 4'h3;
      end else begin
        p0_addr = 32'hBAD0_0000; p0_wdata = 32'hFFFF_0000; p0_wstrb = 4'h3;
      end
    end
    if (drop) begin
      if (port == 1) p1_valid = 1'b0; else p0_valid = 1'b0;
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, m_valid}, 32'd1);
      check("hold_addr", m_addr, e_addr);
      check("hold_wdata", m_wdata, e_wdata);
      check("hold_wstrb", {28'd0, m_wstrb}, {28'd0, e_wstrb});
      check("hold_readys", {30'd0, p1_ready, p0_ready}, 32'd0);
    end
    m_ready = 1'b1;
    m_rdata = rdata;
    @(posedge clk);
    #1;
    m_ready = stray;
    m_rdata = 32'h5555_AAAA;
    if (port == 1) exp_rd1 = rdata; else exp_rd0 = rdata;
    @(negedge clk);
    check("resp_readys", {30'd0, p1_ready, p0_ready}, (port == 1) ? 32'd2 : 32'd1);
    check("resp_rdata0", p0_rdata, exp_rd0);
    check("resp_rdata1", p1_rdata, exp_rd1);
    check("resp_m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    m_ready = 1'b0;
    check("idle_readys", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_rdata0", p0_rdata, exp_rd0);
    check("idle_rdata1", p1_rdata, exp_rd1);
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
    check("rst_readys", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("rst_rdata0", p0_rdata, 32'd0);
    check("rst_rdata1", p1_rdata, 32'd0);
    check("rst_grant_busy", {30'd0, grant, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests alternate, port 0 first after reset
    p0_addr = 32'h100; p1_addr = 32'h200;
    p0_wdata = 32'hA0; p1_wdata = 32'hA1;
    p0_valid = 1'b1; p1_valid = 1'b1;
    run_txn(0, 0, 32'h0000_0100, 32'h100, 32'hA0, 4'h0, 0, 0, 0);
    run_txn(1, 0, 32'h0000_0200, 32'h200, 32'hA1, 4'h0, 0, 0, 0);
    run_txn(0, 1, 32'h0000_0101, 32'h100, 32'hA0, 4'h0, 0, 0, 0);
    run_txn(1, 0, 32'h0000_0201, 32'h200, 32'hA1, 4'h0, 0, 0, 0);
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clk);
    check("sim_quiet", {31'd0, m_valid}, 32'd0);

    // Single read on p0, valid dropped during REQ, m_ready 2 cycles after m_valid
    p0_addr = 32'h10; p0_wdata = 32'h0; p0_wstrb = 4'h0; p0_valid = 1'b1;
    run_txn(0, 2, 32'hDEAD_BEEF, 32'h10, 32'h0, 4'h0, 1, 0, 0);
    check("read_rdata", p0_rdata, 32'hDEAD_BEEF);

    // p1 write with fields changed during a 5-cycle REQ
    p1_addr = 32'h4; p1_wdata = 32'h1111_1111; p1_wstrb = 4'hF; p1_valid = 1'b1;
    run_txn(1, 5, 32'h0000_0000, 32'h4, 32'h1111_1111, 4'hF, 0, 1, 0);
    p1_valid = 1'b0;
    @(negedge clk);
    check("hold_no_reissue", {31'd0, m_valid}, 32'd0);

    // Write then read streaming on p0; final transaction also carries a stray m_ready in RESP
    p0_addr = 32'h40; p0_wdata = 32'h1111_1112; p0_wstrb = 4'hF; p0_valid = 1'b1;
    run_txn(0, 1, 32'h0000_0007, 32'h40, 32'h1111_1112, 4'hF, 0, 0, 0);
    p0_wstrb = 4'h0;
    run_txn(0, 0, 32'hCAFE_F00D, 32'h40, 32'h1111_1112, 4'h0, 1, 0, 1);
    @(negedge clk);
    check("stream_quiet", {31'd0, m_valid}, 32'd0);

    // Stray m_ready while IDLE
    m_ready = 1'b1;
    m_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("stray_m_valid", {31'd0, m_valid}, 32'd0);
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_readys", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("stray_rdata0", p0_rdata, exp_rd0);
    m_ready = 1'b0;

    // Reset asserted during REQ
    p0_addr = 32'h300; p0_valid = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (m_valid) seen = 1;
      end
      check("rst_req_seen", {31'd0, seen}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    exp_rd0 = '0; exp_rd1 = '0;
    check("arst_m_valid", {31'd0, m_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_readys", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("arst_m_addr", m_addr, 32'd0);
    check("arst_rdata0", p0_rdata, 32'd0);
    p0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_pulse", {30'd0, p1_ready, p0_ready}, 32'd0);
    rst_n = 1'b1;
    p1_addr = 32'h200; p1_wdata = 32'h0; p1_wstrb = 4'h0;
    p0_valid = 1'b1; p1_valid = 1'b1;
    run_txn(0, 0, 32'h0000_0300, 32'h300, 32'h1111_1112, 4'h0, 0, 0, 0);
    run_txn(1, 0, 32'h0000_0400, 32'h200, 32'h0, 4'h0, 0, 0, 0);
    p0_valid = 1'b0; p1_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester round-robin arbiter that shares the single `sys_sdram` valid/ready request port between two masters (e.g. CPU bus and DMA/video fetch). Sits directly in front of `sys_sdram` and presents each master with its own valid/ready port. Requests are registered toward the controller; read data and ready are registered back to the granted master. One transaction is in flight at a time.

## Interface
- `ADDR_W`, 32, address width (all ports)
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`

- `clk`  in  1  single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `p0_valid`  in  1  port 0 request valid
- `p0_ready`  out  1  port 0 transaction complete (one-cycle pulse)
- `p0_addr`  in  ADDR_W  port 0 address
- `p0_wdata`  in  DATA_W  port 0 write data
- `p0_wstrb`  in  DATA_W/8  port 0 byte strobes; all-zero = read
- `p0_rdata`  out  DATA_W  port 0 read data, valid with `p0_ready`
- `p1_valid`, `p1_ready`, `p1_addr`, `p1_wdata`, `p1_wstrb`, `p1_rdata`: same as port 0, for port 1
- `m_valid`  out  1  request to `sys_sdram` `i_valid`
- `m_ready`  in  1  from `sys_sdram` `o_ready`
- `m_addr`  out  ADDR_W  to `i_addr`
- `m_wdata`  out  DATA_W  to `i_wdata`
- `m_wstrb`  out  DATA_W/8  to `i_wstrb`
- `m_rdata`  in  DATA_W  from `o_rdata`
- `grant`  out  1  port currently owning the controller (0/1)
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: if no `pX_valid`, stay. If exactly one valid, grant it. If both valid, grant `~last_grant`. Register granted port's addr/wdata/wstrb into `m_*`, set `grant`, `last_grant <= granted port`, go REQ.
- REQ: `m_valid = 1`; `m_addr/m_wdata/m_wstrb` held stable. On `m_ready`: capture `m_rdata` into granted port's rdata register, go RESP. Requester fields are not re-sampled in REQ (requester changes are ignored until completion).
- RESP: granted `pX_ready = 1` for exactly this cycle; `m_valid = 0`; go IDLE unconditionally. The requester updates its fields on this edge; arbiter samples them only in IDLE, so stale requests are never issued.
- `m_ready` outside REQ is ignored.
- Non-granted port's ready stays 0; its rdata register keeps its last value.
- `last_grant` resets to 1, so port 0 wins the first simultaneous request.
- `pX_valid` dropped while in REQ does not abort; transaction completes and ready still pulses.

## Timing
- Reset values: `m_valid=0`, `m_addr=0`, `m_wdata=0`, `m_wstrb=0`, `p0_ready=p1_ready=0`, `p0_rdata=p1_rdata=0`, `grant=0`, `busy=0`, state IDLE, `last_grant=1`.
- All outputs registered (no combinational path from any input to any output).
- Request at IDLE cycle T -> `m_valid` high from T+1. `m_ready` at cycle K (K >= T+1) -> `pX_ready` and `pX_rdata` at K+1 -> IDLE at K+2.
- Minimum 3 cycles per transaction (`m_ready` in first REQ cycle); back-to-back throughput one transaction per 3 cycles plus controller latency.
- Reset asserted mid-transaction: all state and outputs clear asynchronously; no ready pulse is produced for the aborted request.

## Test plan
- Single read: p0 valid, addr=0x10, wstrb=0; controller model returns 0xDEADBEEF with `m_ready` 2 cycles after `m_valid` -> `m_addr=0x10`, `m_wstrb=0`, `p0_ready` one cycle, `p0_rdata=0xDEADBEEF`, `p1_ready` stays 0.
- Simultaneous: both ports hold valid continuously, p0 addr=0x100, p1 addr=0x200 -> `m_addr` sequence 0x100, 0x200, 0x100, 0x200; `grant` alternates 0,1,0,1.
- Hold stability: p1 write addr=0x4, wdata=0x11111111, wstrb=0xF; change p1 fields during REQ, delay `m_ready` 5 cycles -> `m_*` unchanged for all REQ cycles, exactly one `p1_ready` pulse.
- Write-then-read streaming (p0 keeps valid high, updates fields on ready: write 0x11111112 then read same addr) -> two distinct `m_valid` transactions, second has `m_wstrb=0`, no duplicate issue of the write.
- Stray `m_ready` while IDLE/RESP -> no state change, no ready pulse.
- Assert `rst_n=0` during REQ -> `m_valid`, `busy`, readys go 0 immediately; after release, p0 wins first simultaneous request.
